// File: rtl/fpga_cd_pkg.sv
// Shared types and helpers for schedulers that time-share one FP core.
// Combinational only: no latency, no handshakes.
package fpga_cd_pkg;
    localparam int FP_W   = 32;
    localparam int RR_MAX = 8;
    localparam int RR_IW  = 3;

    typedef enum logic [2:0] {IDLE, OP1, Z1, OP2, Z2, HOLD} state_t;

    typedef struct packed {
        logic [FP_W-1:0] a1;
        logic [FP_W-1:0] a2;
        logic [FP_W-1:0] a3;
    } ops_t;

    typedef struct packed {
        logic             found;
        logic [RR_IW-1:0] idx;
    } rr_pick_t;

    // First set bit of req at or after ptr, wrapping within n requesters.
    function automatic rr_pick_t rr_pick(input logic [RR_MAX-1:0] req,
                                         input logic [RR_IW-1:0]  ptr,
                                         input int                n);
        rr_pick_t         r;
        logic [RR_IW-1:0] idx;
        r = '0;
        for (int k = 0; k < RR_MAX; k++) begin
            idx = RR_IW'((int'(ptr) + k) % n);
            if (k < n && !r.found && req[idx]) begin
                r.found = 1'b1;
                r.idx   = idx;
            end
        end
        return r;
    endfunction
endpackage

// File: rtl/rr_arbiter.sv
// Round-robin pick over NREQ requests; pointer moves past each accepted winner.
// Latency: pick is combinational, pointer updates on the accepting edge.
// Backpressure: the pointer only advances when the caller asserts advance.
module rr_arbiter #(
    parameter int NREQ = 4,
    parameter int IDW  = 2
) (
    input  logic            CLK,
    input  logic            reset,
    input  logic [NREQ-1:0] req,
    input  logic            advance,
    output logic            found,
    output logic [IDW-1:0]  winner
);
    import fpga_cd_pkg::*;

    rr_pick_t       pick;
    logic [IDW-1:0] ptr_q;

    always_comb begin
        pick   = rr_pick(RR_MAX'(req), RR_IW'(ptr_q), NREQ);
        // The range guard also keeps the wide helper index fully consumed.
        found  = pick.found && ({1'b0, pick.idx} < (RR_IW+1)'(NREQ));
        winner = pick.idx[IDW-1:0];
    end

    always_ff @(posedge CLK) begin
        if (reset) begin
            ptr_q <= '0;
        end else if (advance && found) begin
            ptr_q <= (winner == IDW'(NREQ-1)) ? '0 : winner + IDW'(1);
        end
    end
endmodule

// File: rtl/add3_sched.sv
// Computes a1+a2+a3 per requester by chaining two ops through one shared FP adder.
// Latency: grant to res_vld is two adder round trips plus at least 4 handshake cycles.
// Backpressure: res is held until res_ack; no new job is arbitrated until then.
module add3_sched
    import fpga_cd_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int IDW  = 2
) (
    input  logic                 CLK,
    input  logic                 reset,
    input  logic [NREQ-1:0]      req,
    input  logic [FP_W*NREQ-1:0] op_a1,
    input  logic [FP_W*NREQ-1:0] op_a2,
    input  logic [FP_W*NREQ-1:0] op_a3,
    output logic [NREQ-1:0]      grant,
    output logic [FP_W-1:0]      res,
    output logic                 res_vld,
    output logic [IDW-1:0]       res_id,
    input  logic                 res_ack,
    output logic [FP_W-1:0]      add_a,
    output logic [FP_W-1:0]      add_b,
    output logic                 add_a_stb,
    output logic                 add_b_stb,
    input  logic                 add_a_ack,
    input  logic                 add_b_ack,
    input  logic [FP_W-1:0]      add_z,
    input  logic                 add_z_stb,
    output logic                 add_z_ack
);
    state_t          state_q;
    state_t          state_d;
    ops_t            ops_q;
    logic [IDW-1:0]  id_q;
    logic [FP_W-1:0] partial_q;
    logic            a_done_q;
    logic            b_done_q;

    logic            arb_found;
    logic [IDW-1:0]  arb_winner;
    logic            accept;
    logic            a_take;
    logic            b_take;
    logic            both_taken;
    logic            op_phase;

    rr_arbiter #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_arb (
        .CLK     (CLK),
        .reset   (reset),
        .req     (req),
        .advance (accept),
        .found   (arb_found),
        .winner  (arb_winner)
    );

    assign accept     = (state_q == IDLE) && arb_found;
    assign op_phase   = (state_q == OP1) || (state_q == OP2);
    assign a_take     = add_a_stb && add_a_ack;
    assign b_take     = add_b_stb && add_b_ack;
    // The two operand ports may be accepted in different cycles.
    assign both_taken = (a_done_q || a_take) && (b_done_q || b_take);

    always_ff @(posedge CLK) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (arb_found)          state_d = OP1;
            OP1:     if (both_taken)         state_d = Z1;
            Z1:      if (add_z_stb)          state_d = OP2;
            OP2:     if (both_taken)         state_d = Z2;
            Z2:      if (add_z_stb)          state_d = HOLD;
            HOLD:    if (res_vld && res_ack) state_d = IDLE;
            default:                         state_d = IDLE;
        endcase
    end

    always_comb begin
        add_a     = '0;
        add_b     = '0;
        add_a_stb = 1'b0;
        add_b_stb = 1'b0;
        case (state_q)
            OP1: begin
                add_a     = ops_q.a1;
                add_b     = ops_q.a2;
                add_a_stb = !a_done_q;
                add_b_stb = !b_done_q;
            end
            OP2: begin
                add_a     = partial_q;
                add_b     = ops_q.a3;
                add_a_stb = !a_done_q;
                add_b_stb = !b_done_q;
            end
            default: ;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (reset || !op_phase || both_taken) begin
            a_done_q <= 1'b0;
            b_done_q <= 1'b0;
        end else begin
            if (a_take) a_done_q <= 1'b1;
            if (b_take) b_done_q <= 1'b1;
        end
    end

    // Operands are frozen at grant; later op_* changes never reach the adder.
    always_ff @(posedge CLK) begin
        if (reset) begin
            grant <= '0;
            ops_q <= '0;
            id_q  <= '0;
        end else begin
            grant <= '0;
            if (accept) begin
                grant    <= NREQ'(1) << arb_winner;
                ops_q.a1 <= op_a1[FP_W*arb_winner +: FP_W];
                ops_q.a2 <= op_a2[FP_W*arb_winner +: FP_W];
                ops_q.a3 <= op_a3[FP_W*arb_winner +: FP_W];
                id_q     <= arb_winner;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (reset) begin
            partial_q <= '0;
            res       <= '0;
            res_vld   <= 1'b0;
            res_id    <= '0;
            add_z_ack <= 1'b0;
        end else begin
            add_z_ack <= 1'b0;
            if (state_q == Z1 && add_z_stb) begin
                partial_q <= add_z;
                add_z_ack <= 1'b1;
            end
            if (state_q == Z2 && add_z_stb) begin
                res       <= add_z;
                res_vld   <= 1'b1;
                res_id    <= id_q;
                add_z_ack <= 1'b1;
            end
            if (state_q == HOLD && res_vld && res_ack) begin
                res_vld <= 1'b0;
            end
        end
    end
endmodule

// File: doc/add3_sched.md
Name: add3_sched

Overview:
- Sequences one shared single-precision FP adder (stb/ack handshake core) to compute a1+a2+a3 for up to NREQ requesters.
- Replaces per-requester pairs of adder instances in the AABB compute path with a single time-shared adder.
- Arbitrates round-robin and chains both additions through the same adder.
- Returns each 32-bit result with a valid/ack handshake tagged by requester index.

Parameters:
- NREQ, 4, number of requesters (2..8)
- IDW, 2, requester index width; must equal clog2(NREQ), minimum 1

Ports:
- CLK  in  1  clock
- reset  in  1  synchronous, active-high reset
- req  in  NREQ  per-requester request; held high with operands stable until grant pulse
- op_a1  in  32*NREQ  operand 1, requester i at bits [32i+31:32i]
- op_a2  in  32*NREQ  operand 2, same packing
- op_a3  in  32*NREQ  operand 3, same packing
- grant  out  NREQ  one-hot, one-cycle pulse when a request is accepted
- res  out  32  sum a1+a2+a3 (IEEE-754 single)
- res_vld  out  1  result valid; held until res_ack
- res_id  out  IDW  index of the requester owning res
- res_ack  in  1  consumer accepts res in any cycle res_vld & res_ack
- add_a  out  32  adder input_a
- add_b  out  32  adder input_b
- add_a_stb  out  1  adder input_a_stb
- add_b_stb  out  1  adder input_b_stb
- add_a_ack  in  1  adder input_a_ack
- add_b_ack  in  1  adder input_b_ack
- add_z  in  32  adder output_z
- add_z_stb  in  1  adder output_z_stb
- add_z_ack  out  1  adder output_z_ack

Behaviour:
- Reset, synchronous, active-high, values: state=IDLE; grant=0; res=0; res_vld=0; res_id=0; all add_* strobes/acks=0; add_a=add_b=0; rr pointer=0; captured operands=0.
- Reset mid-operation aborts the job with no result. The adder is reset from the same reset net.
- IDLE:
  - If any req, pick the first set bit at or after rr pointer (wrapping) and pulse grant for 1 cycle.
  - Latch a1/a2/a3 and the index into internal regs; rr pointer = winner+1 mod NREQ.
  - Go to OP1.
  - No req: stay in IDLE.
- OP1:
  - add_a=a1, add_b=a2; add_a_stb/add_b_stb high.
  - Each strobe drops the cycle after its ack is sampled; a and b may be accepted in different cycles (track a_done/b_done).
  - When both are accepted, go to Z1.
- Z1:
  - Wait for add_z_stb; on it capture add_z into partial and assert add_z_ack for exactly 1 cycle.
  - Go to OP2.
- OP2: same as OP1 with add_a=partial, add_b=a3 (latched copy); then go to Z2.
- Z2:
  - On add_z_stb capture into res, pulse add_z_ack, set res_vld=1 and res_id=index.
  - Go to HOLD.
- HOLD:
  - res, res_vld and res_id held stable until res_ack; on res_vld & res_ack clear res_vld and go to IDLE.
  - Arbitration for the next job starts in IDLE, so back-to-back throughput is one job per (2 adder ops + 2) cycles minimum.
- Latency: grant to res_vld = 2*(adder latency) + handshake cycles, at least 4 cycles beyond the adder pipelines.
- Operands are sampled only at grant; later changes to op_* from the granted requester are ignored.
- No requester is granted twice while another requester has req high continuously (round-robin fairness).
- Boundary cases:
  - res_ack while res_vld=0 is ignored.
  - add_z_stb outside Z1/Z2 is ignored (no ack).
  - Widths are fixed at 32; no rounding or format handling here, as the adder owns the arithmetic.

Decomposition:
- Shared package fpga_cd_pkg holds:
  - FP_W=32
  - state enum {IDLE, OP1, Z1, OP2, Z2, HOLD}
  - function rr_pick(req, ptr) returning index and found flag
- Natural sub-module: rr_arbiter (NREQ-wide round-robin, combinational pick + registered pointer), reusable by other shared-FP schedulers.
- Adder instance stays outside; the testbench instantiates the real adder.

Test Plan:
- Single request:
  - Stimulus: req=0001, a1=1.0 (0x3F800000), a2=2.0 (0x40000000), a3=3.0 (0x40400000).
  - Required: grant=0001 pulse, then res=0x40C00000 (6.0), res_id=0, res_vld held until res_ack.
- Round-robin with all requests:
  - Stimulus: req=1111 held, each requester with distinct operands, res_ack tied high.
  - Required: grants in order 0,1,2,3,0; each res matches its own requester's sum and res_id.
- Back-pressure:
  - Stimulus: res_ack held low for 20 cycles after res_vld.
  - Required: res, res_id and res_vld stable throughout; no new grant until ack.
- Staggered adder acks:
  - Stimulus: adder model delays input_b_ack 3 cycles after input_a_ack.
  - Required: add_a_stb drops after a_ack while add_b_stb stays high; correct sum.
- Cancellation:
  - Stimulus: a1=1.5, a2=-1.5, a3=-0.0.
  - Required: res=0x00000000.
- Reset mid-operation:
  - Stimulus: reset in Z1.
  - Required: next cycle state=IDLE, res_vld=0, grant=0; the following request completes normally with rr pointer=0.
